mips_alu_muldiv: RTL and testbench

//  Parametrised MIPS ALU with an iterative multiply/divide unit and architectural HI/LO registers.
//  - Single-cycle logic/arith ops: AND, OR, ADD, SUB, SLT, NOR.
//  - Multi-cycle MULT/MULTU/DIV/DIVU write HI/LO. MFHI/MFLO read them back.
//  - Sits in the EX stage. The pipeline stalls while in_ready is low.

---
 rtl/mips_alu_muldiv.sv | 167 ++++++++++++++++
 tb/tb_mips_alu_muldiv.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mips_alu_muldiv.sv
// MIPS EX-stage ALU: single-cycle logic/arith ops plus an iterative 1-bit/cycle
// multiply/divide unit that owns the architectural HI/LO registers.
module mips_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] Read_data1,
  input  logic [WIDTH-1:0] Read_data2,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUresult,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MFHI = 4'b1101;
  localparam logic [3:0] OP_MFLO = 4'b1110;

  typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_e;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic             op_div;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] operand_mag;

  // 1000..1011 are MULT/MULTU/DIV/DIVU; bit 1 selects divide, bit 0 unsigned.
  logic is_muldiv, is_div, is_signed, div_by_zero;
  logic sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_muldiv   = (ALU_Control[3:2] == 2'b10);
  assign is_div      = is_muldiv && ALU_Control[1];
  assign is_signed   = !ALU_Control[0];
  assign div_by_zero = is_div && (Read_data2 == '0);
  assign sign_a      = is_signed && Read_data1[WIDTH-1];
  assign sign_b      = is_signed && Read_data2[WIDTH-1];
  assign mag_a       = sign_a ? -Read_data1 : Read_data1;
  assign mag_b       = sign_b ? -Read_data2 : Read_data2;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  logic [WIDTH-1:0] single_result;

  // NOTE: every variable assigned in always_comb gets a default first so no path can infer a latch.
  always_comb begin
    single_result = '0;
    case (ALU_Control)
      OP_AND:  single_result = Read_data1 & Read_data2;
      OP_OR:   single_result = Read_data1 | Read_data2;
      OP_ADD:  single_result = Read_data1 + Read_data2;
      OP_SUB:  single_result = Read_data1 - Read_data2;
      OP_SLT:  single_result = {{(WIDTH-1){1'b0}}, ($signed(Read_data1) < $signed(Read_data2))};
      OP_NOR:  single_result = ~(Read_data1 | Read_data2);
      OP_MFHI: single_result = hi;
      OP_MFLO: single_result = lo;
      default: single_result = '0;
    endcase
  end

  // Multiply: shift-add with the multiplier in work_lo. Divide: restoring, the
  // dividend shifts out of work_lo into the remainder while quotient bits shift in.
  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand_mag} : '0);
  assign div_shift = {work_hi, work_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, operand_mag};

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  assign prod_neg = -{work_hi, work_lo};

  always_comb begin
    fix_hi = work_hi;
    fix_lo = work_lo;
    if (op_div) begin
      if (neg_q) fix_lo = -work_lo;
      if (neg_r) fix_hi = -work_hi;
    end else if (neg_q) begin
      {fix_hi, fix_lo} = prod_neg;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      work_hi     <= '0;
      work_lo     <= '0;
      operand_mag <= '0;
      ALUresult   <= '0;
      div_zero    <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (div_by_zero) begin
              hi        <= Read_data1;
              lo        <= '1;
              ALUresult <= '1;
              div_zero  <= 1'b1;
              state     <= DONE;
            end else if (is_muldiv) begin
              op_div      <= is_div;
              neg_q       <= sign_a ^ sign_b;
              neg_r       <= sign_a;
              work_hi     <= '0;
              work_lo     <= is_div ? mag_a : mag_b;
              operand_mag <= is_div ? mag_b : mag_a;
              cnt         <= '0;
              state       <= ITER;
            end else begin
              ALUresult <= single_result;
              div_zero  <= 1'b0;
              state     <= DONE;
            end
          end
        end
        ITER: begin
          if (op_div) begin
            if (!div_diff[WIDTH]) begin
              work_hi <= div_diff[WIDTH-1:0];
              work_lo <= {work_lo[WIDTH-2:0], 1'b1};
            end else begin
              work_hi <= div_shift[WIDTH-1:0];
              work_lo <= {work_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {work_hi, work_lo} <= {mul_sum, work_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIXUP;
        end
        FIXUP: begin
          hi        <= fix_hi;
          lo        <= fix_lo;
          ALUresult <= fix_lo;
          div_zero  <= 1'b0;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Directed bench for mips_alu_muldiv: hand-computed results, latencies,
// HI/LO behaviour, divide-by-zero and mid-operation reset.
module tb_mips_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [3:0]   alu_control = 4'b0;
  logic [W-1:0] read_data1 = '0;
  logic [W-1:0] read_data2 = '0;
  logic         in_ready, out_valid, div_zero;
  logic [W-1:0] alu_result, hi, lo;

  int  checks = 0;
  int  failures = 0;
  int  lat;
  int  ready_high;
  int  pulses;
  time accept_t, first_t;

  mips_alu_muldiv #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALU_Control (alu_control),
    .Read_data1  (read_data1),
    .Read_data2  (read_data2),
    .out_valid   (out_valid),
    .ALUresult   (alu_result),
    .div_zero    (div_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its out_valid; lat counts cycles after the accept edge.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1; alu_control = op; read_data1 = a; read_data2 = b;
    @(posedge clk);
    accept_t = $time;
    #1 in_valid = 1'b0;
    lat = 0;
    ready_high = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) ready_high++;
    end
    if (!out_valid) lat = 999;
  endtask

  task automatic check_pulse_end(input string tag);
    @(negedge clk);
    check({tag, "_ov_drop"}, 64'(out_valid), 64'(0));
    check({tag, "_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(alu_result), 64'(0));
    check("rst_div_zero", 64'(div_zero), 64'(0));
    check("rst_hilo", {hi, lo}, 64'(0));
    reset = 1'b0;

    // Single-cycle ops
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h1);
    check("add_lat", 64'(lat), 64'(1));
    check("add_wrap", 64'(alu_result), 64'(0));
    check_pulse_end("add");
    run_op(4'b0110, 32'h0, 32'h1);
    check("sub", 64'(alu_result), 64'hFFFF_FFFF);
    run_op(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("and", 64'(alu_result), 64'h00F0_00F0);
    run_op(4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("or", 64'(alu_result), 64'hFFF0_FFF0);
    run_op(4'b0111, 32'h8000_0000, 32'h1);
    check("slt_neg", 64'(alu_result), 64'(1));
    run_op(4'b0111, 32'h1, 32'h8000_0000);
    check("slt_pos", 64'(alu_result), 64'(0));
    run_op(4'b1100, 32'h0, 32'h0);
    check("nor", 64'(alu_result), 64'hFFFF_FFFF);

    // Multiply
    run_op(4'b1000, 32'hFFFF_FFFD, 32'h5);
    check("mult_lat", 64'(lat), 64'(W + 2));
    check("mult_busy", 64'(ready_high), 64'(0));
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check("mult_result", 64'(alu_result), 64'hFFFF_FFF1);
    check_pulse_end("mult");
    run_op(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_lat", 64'(lat), 64'(W + 2));
    check("multu_busy", 64'(ready_high), 64'(0));
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(4'b1111, 32'h1234, 32'h5678);
    check("unknown_result", 64'(alu_result), 64'(0));
    check("unknown_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(4'b0010, 32'h1, 32'h1);
    check("add_keeps_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Divide
    run_op(4'b1010, 32'hFFFF_FFF9, 32'h2);
    check("div_lat", 64'(lat), 64'(W + 2));
    check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_neg_result", 64'(alu_result), 64'hFFFF_FFFD);
    run_op(4'b1011, 32'd100, 32'd7);
    check("divu_hilo", {hi, lo}, {32'd2, 32'd14});
    check("divu_dz", 64'(div_zero), 64'(0));
    run_op(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_minneg_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(4'b1101, 32'h0, 32'h0);
    check("mfhi", 64'(alu_result), 64'(0));
    run_op(4'b1110, 32'h0, 32'h0);
    check("mflo", 64'(alu_result), 64'h8000_0000);

    // Divide by zero
    run_op(4'b1011, 32'd9, 32'd0);
    check("dz_lat", 64'(lat), 64'(1));
    check("dz_flag", 64'(div_zero), 64'(1));
    check("dz_hilo", {hi, lo}, 64'h0000_0009_FFFF_FFFF);
    check("dz_result", 64'(alu_result), 64'hFFFF_FFFF);
    run_op(4'b0010, 32'd2, 32'd3);
    check("dz_clear", 64'(div_zero), 64'(0));
    check("dz_next_add", 64'(alu_result), 64'(5));

    // Back-to-back single ops: one accept every 2 cycles
    run_op(4'b0010, 32'd10, 32'd20);
    first_t = accept_t;
    check("b2b_first", 64'(alu_result), 64'(30));
    run_op(4'b0110, 32'd50, 32'd8);
    check("b2b_second", 64'(alu_result), 64'(42));
    check("b2b_spacing", 64'(accept_t - first_t), 64'(20));

    // Reset during ITER cycle 10 of a MULT
    @(negedge clk);
    in_valid = 1'b1; alu_control = 4'b1000; read_data1 = 32'd7; read_data2 = 32'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_busy", 64'(in_ready), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_ready", 64'(in_ready), 64'(1));
    check("rst_mid_hilo", {hi, lo}, 64'(0));
    check("rst_mid_ov", 64'(out_valid), 64'(0));
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("rst_mid_no_pulse", 64'(pulses), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
